// File: rtl/spi_read_cache.sv
// spi_read_cache: direct-mapped write-through byte cache in front of an SPI memory controller
module spi_read_cache #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ready,
  input  logic              cache_en,
  input  logic              flush,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int LINES = 2**IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;
  typedef enum logic [2:0] {IDLE, HIT_RESP, FILL, WRITE, DONE, FLUSH} state_t;
  state_t state;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic flush_pend;
  logic [IDX_W-1:0] req_idx, ext_idx;
  logic req_hit, ext_hit;
  assign req_idx = mem_addr[IDX_W-1:0];
  assign ext_idx = ext_addr[IDX_W-1:0];
  assign req_hit = cache_en && valid[req_idx] && tag_q[req_idx] == mem_addr[ADDR_W-1:IDX_W];
  assign ext_hit = cache_en && valid[ext_idx] && tag_q[ext_idx] == ext_addr[ADDR_W-1:IDX_W];
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      flush_pend <= 1'b0;
      mem_rdata  <= '0;
      mem_ready  <= 1'b0;
      ext_req    <= 1'b0;
      ext_we     <= 1'b0;
      ext_addr   <= '0;
      ext_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (flush && state != IDLE) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush || flush_pend) state <= FLUSH;
          else if (mem_req) begin
            ext_addr  <= mem_addr;
            ext_wdata <= mem_wdata;
            ext_we    <= mem_we;
            if (!mem_we && req_hit) begin
              state     <= HIT_RESP;
              mem_ready <= 1'b1;
              mem_rdata <= data_q[req_idx];
              hit_count <= hit_count + 16'(hit_count != '1);
            end else begin
              state   <= mem_we ? WRITE : FILL;
              ext_req <= 1'b1;
            end
          end
        end
        FILL, WRITE: begin
          if (ext_ready) begin
            ext_req   <= 1'b0;
            mem_ready <= 1'b1;
            state     <= DONE;
            if (state == FILL) begin
              mem_rdata <= ext_rdata;
              if (cache_en) begin
                valid[ext_idx]  <= 1'b1;
                tag_q[ext_idx]  <= ext_addr[ADDR_W-1:IDX_W];
                data_q[ext_idx] <= ext_rdata;
                miss_count      <= miss_count + 16'(miss_count != '1);
              end
            end else if (ext_hit) data_q[ext_idx] <= ext_wdata;
          end
        end
        HIT_RESP, DONE: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
        FLUSH: begin
          valid      <= '0;
          flush_pend <= flush;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_read_cache.sv
// tb_spi_read_cache: randomized and directed checks of spi_read_cache against a behavioural cache model
module tb_spi_read_cache;
  logic clk = 1'b0;
  logic reset, mem_req, mem_we, mem_ready, ext_req, ext_we, cache_en, flush;
  logic [15:0] mem_addr, ext_addr, hit_count, miss_count;
  logic [7:0] mem_wdata, mem_rdata, ext_wdata;
  logic [7:0] ext_rdata = 8'h00;
  logic ext_ready = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] ext_mem [65536];
  logic [7:0] ref_mem [65536];
  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] wdata;} ext_t;
  ext_t ext_log [$];
  int ext_lat = 0;
  int resp_lat = 0;
  logic m_valid [16];
  logic [11:0] m_tag [16];
  logic [7:0] m_data [16];
  int m_hits, m_misses;
  always #5 clk = ~clk;
  spi_read_cache dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ext_req(ext_req),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .ext_ready(ext_ready), .cache_en(cache_en), .flush(flush), .hit_count(hit_count),
    .miss_count(miss_count)
  );
  initial begin : responder
    int cnt;
    cnt = 0;
    for (int i = 0; i < 65536; i++) ext_mem[i] = 8'($urandom);
    ext_mem[16'h0010] = 8'hA5;
    forever begin
      @(negedge clk);
      ext_ready = 1'b0;
      if (!ext_req) cnt = 0;
      else begin
        if (cnt == 0) begin
          ext_log.push_back({ext_we, ext_addr, ext_wdata});
          cnt = ext_lat > 0 ? ext_lat : int'($urandom_range(1, 4));
          resp_lat = cnt;
        end
        cnt--;
        if (cnt == 0) begin
          ext_ready = 1'b1;
          ext_rdata = ext_mem[ext_addr];
          if (ext_we) ext_mem[ext_addr] = ext_wdata;
        end
      end
    end
  end
  function automatic void model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endfunction
  function automatic void model_op(input logic we, input logic [15:0] a, input logic [7:0] wd,
                                   input logic en, output logic [7:0] rd, output logic hit);
    int i = int'(a[3:0]);
    hit = en && m_valid[i] && m_tag[i] == a[15:4];
    rd = hit ? m_data[i] : ref_mem[a];
    if (we) begin
      ref_mem[a] = wd;
      if (hit) m_data[i] = wd;
    end else if (hit) m_hits = m_hits < 65535 ? m_hits + 1 : 65535;
    else if (en) begin
      m_valid[i] = 1'b1;
      m_tag[i] = a[15:4];
      m_data[i] = rd;
      m_misses = m_misses < 65535 ? m_misses + 1 : 65535;
    end
  endfunction
  function automatic ext_t last_ext();
    return ext_log.size() > 0 ? ext_log[ext_log.size()-1] : '0;
  endfunction
  task automatic apply_reset();
    reset = 1'b1;
    mem_req = 1'b0;
    flush = 1'b0;
    cache_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    m_hits = 0;
    m_misses = 0;
  endtask
  task automatic do_op(input logic we, input logic [15:0] a, input logic [7:0] wd, input int fl_at,
                       output logic [7:0] rd, output int lat, output int n_ext);
    int n0;
    @(posedge clk);
    #1;
    n0 = ext_log.size();
    mem_we = we;
    mem_addr = a;
    mem_wdata = wd;
    mem_req = 1'b1;
    flush = (fl_at == 0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      flush = (lat == fl_at);
    end while (!mem_ready && lat < 60);
    checks++;
    if (!mem_ready) begin
      errors++;
      $display("FAIL op_timeout addr=%h got no mem_ready want mem_ready within 60 cycles", a);
    end
    rd = mem_rdata;
    n_ext = ext_log.size() - n0;
    mem_req = 1'b0;
    flush = 1'b0;
  endtask
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({mem_ready, ext_req, ext_we} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got ready/req/we=%b want 000", {mem_ready, ext_req, ext_we});
    end
    checks++;
    if ({mem_rdata, ext_addr, ext_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", mem_rdata, ext_addr, ext_wdata);
    end
    checks++;
    if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_counts got hit=%h miss=%h want 0", hit_count, miss_count);
    end
  endtask
  task automatic test_basic();
    logic [7:0] rd;
    int lat, n;
    ext_t e;
    do_op(1'b0, 16'h0010, 8'h00, -1, rd, lat, n);
    e = last_ext();
    checks++;
    if (rd !== 8'hA5) begin errors++; $display("FAIL basic_miss_rdata got=%h want=a5", rd); end
    checks++;
    if (n !== 1 || e.we !== 1'b0 || e.addr !== 16'h0010) begin
      errors++;
      $display("FAIL basic_miss_ext got n=%0d we=%b addr=%h want n=1 we=0 addr=0010", n, e.we, e.addr);
    end
    checks++;
    if (lat !== resp_lat + 1) begin errors++; $display("FAIL basic_miss_latency got=%0d want=%0d", lat, resp_lat + 1); end
    checks++;
    if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL basic_miss_counts got hit=%0d miss=%0d want hit=0 miss=1", hit_count, miss_count);
    end
    do_op(1'b0, 16'h0010, 8'h00, -1, rd, lat, n);
    checks++;
    if (rd !== 8'hA5 || n !== 0 || lat !== 1) begin
      errors++;
      $display("FAIL basic_hit got rdata=%h n_ext=%0d lat=%0d want a5 0 1", rd, n, lat);
    end
    checks++;
    if (hit_count !== 16'd1) begin errors++; $display("FAIL basic_hit_count got=%0d want=1", hit_count); end
    @(posedge clk);
    #1;
    checks++;
    if (mem_ready !== 1'b0 || ext_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_pulse got ready=%b req=%b want 0 0", mem_ready, ext_req);
    end
  endtask
  task automatic test_conflict();
    logic [7:0] rd;
    int lat, n, total;
    logic [15:0] seq [3] = '{16'h0010, 16'h0110, 16'h0010};
    apply_reset();
    total = 0;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, seq[i], 8'h00, -1, rd, lat, n);
      total += n;
      checks++;
      if (rd !== ext_mem[seq[i]]) begin
        errors++;
        $display("FAIL conflict_rdata[%0d] got=%h want=%h", i, rd, ext_mem[seq[i]]);
      end
    end
    checks++;
    if (total !== 3 || miss_count !== 16'd3 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL conflict_counts got ext=%0d miss=%0d hit=%0d want 3 3 0", total, miss_count, hit_count);
    end
  endtask
  task automatic test_write();
    logic [7:0] rd;
    int lat, n;
    ext_t e;
    do_op(1'b1, 16'h0010, 8'h3C, -1, rd, lat, n);
    e = last_ext();
    checks++;
    if (n !== 1 || e !== {1'b1, 16'h0010, 8'h3C}) begin
      errors++;
      $display("FAIL write_hit_ext got n=%0d rec=%h want n=1 rec=%h", n, e, {1'b1, 16'h0010, 8'h3C});
    end
    checks++;
    if (miss_count !== 16'd3 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL write_counts got hit=%0d miss=%0d want 0 3", hit_count, miss_count);
    end
    do_op(1'b0, 16'h0010, 8'h00, -1, rd, lat, n);
    checks++;
    if (rd !== 8'h3C || n !== 0 || hit_count !== 16'd1) begin
      errors++;
      $display("FAIL write_hit_readback got rdata=%h n_ext=%0d hit=%0d want 3c 0 1", rd, n, hit_count);
    end
    do_op(1'b1, 16'h0020, 8'h77, -1, rd, lat, n);
    e = last_ext();
    checks++;
    if (n !== 1 || e !== {1'b1, 16'h0020, 8'h77}) begin
      errors++;
      $display("FAIL write_miss_ext got n=%0d rec=%h want n=1 rec=%h", n, e, {1'b1, 16'h0020, 8'h77});
    end
    do_op(1'b0, 16'h0020, 8'h00, -1, rd, lat, n);
    checks++;
    if (rd !== 8'h77 || n !== 1 || miss_count !== 16'd4) begin
      errors++;
      $display("FAIL write_no_allocate got rdata=%h n_ext=%0d miss=%0d want 77 1 4", rd, n, miss_count);
    end
  endtask
  task automatic test_flush();
    logic [7:0] rd;
    int lat, n;
    apply_reset();
    do_op(1'b0, 16'h0010, 8'h00, -1, rd, lat, n);
    do_op(1'b0, 16'h0010, 8'h00, 0, rd, lat, n);
    checks++;
    if (rd !== 8'h3C || n !== 1 || miss_count !== 16'd2 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL flush_with_req got rdata=%h n_ext=%0d miss=%0d hit=%0d want 3c 1 2 0",
               rd, n, miss_count, hit_count);
    end
    do_op(1'b0, 16'h0030, 8'h00, 1, rd, lat, n);
    do_op(1'b0, 16'h0030, 8'h00, -1, rd, lat, n);
    checks++;
    if (rd !== ext_mem[16'h0030] || n !== 1 || miss_count !== 16'd4 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL flush_pending got rdata=%h n_ext=%0d miss=%0d hit=%0d want %h 1 4 0",
               rd, n, miss_count, hit_count, ext_mem[16'h0030]);
    end
  endtask
  task automatic test_bypass();
    logic [7:0] rd;
    int lat, n;
    apply_reset();
    cache_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_op(1'b0, 16'h0010, 8'h00, -1, rd, lat, n);
      checks++;
      if (rd !== 8'h3C || n !== 1 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
        errors++;
        $display("FAIL bypass_read[%0d] got rdata=%h n_ext=%0d hit=%0d miss=%0d want 3c 1 0 0",
                 i, rd, n, hit_count, miss_count);
      end
    end
    cache_en = 1'b1;
    do_op(1'b0, 16'h0010, 8'h00, -1, rd, lat, n);
    checks++;
    if (n !== 1 || miss_count !== 16'd1) begin
      errors++;
      $display("FAIL bypass_no_fill got n_ext=%0d miss=%0d want 1 1", n, miss_count);
    end
    do_op(1'b0, 16'h0010, 8'h00, -1, rd, lat, n);
    checks++;
    if (n !== 0 || hit_count !== 16'd1) begin
      errors++;
      $display("FAIL bypass_reenable_hit got n_ext=%0d hit=%0d want 0 1", n, hit_count);
    end
  endtask
  task automatic test_reset_mid();
    logic [7:0] rd;
    int lat, n;
    logic seen;
    apply_reset();
    do_op(1'b0, 16'h0010, 8'h00, -1, rd, lat, n);
    ext_lat = 20;
    @(posedge clk);
    #1;
    mem_we = 1'b0;
    mem_addr = 16'h0040;
    mem_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ext_req !== 1'b1) begin errors++; $display("FAIL reset_mid_fill got ext_req=%b want 1", ext_req); end
    reset = 1'b1;
    mem_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (ext_req !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort got req=%b ready=%b want 0 0", ext_req, mem_ready);
    end
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (mem_ready || ext_req) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_quiet got activity=%b hit=%0d miss=%0d want 0 0 0", seen, hit_count, miss_count);
    end
    ext_lat = 0;
    do_op(1'b0, 16'h0010, 8'h00, -1, rd, lat, n);
    checks++;
    if (n !== 1 || miss_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_mid_invalid got n_ext=%0d miss=%0d want 1 1", n, miss_count);
    end
  endtask
  task automatic test_saturation();
    logic [7:0] rd;
    int lat, n;
    apply_reset();
    do_op(1'b0, 16'h0050, 8'h00, -1, rd, lat, n);
    force dut.hit_count = 16'hFFFE;
    @(posedge clk);
    #1 release dut.hit_count;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 16'h0050, 8'h00, -1, rd, lat, n);
      checks++;
      if (hit_count !== 16'hFFFF || n !== 0) begin
        errors++;
        $display("FAIL hit_saturate[%0d] got hit=%h n_ext=%0d want ffff 0", i, hit_count, n);
      end
    end
    checks++;
    if (miss_count !== 16'd1) begin errors++; $display("FAIL saturate_miss got=%0d want=1", miss_count); end
  endtask
  task automatic test_random();
    logic [11:0] tags [4] = '{12'h000, 12'h001, 12'hFFF, 12'h5A3};
    int prev_fl;
    ext_t e;
    apply_reset();
    for (int i = 0; i < 65536; i++) ref_mem[i] = ext_mem[i];
    prev_fl = -1;
    for (int k = 0; k < 300; k++) begin
      logic we, hit, en;
      logic [15:0] a;
      logic [7:0] wd, rd, exp_rd;
      int fl, lat, n, exp_lat;
      we = $urandom_range(0, 3) == 0;
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
      wd = 8'($urandom);
      en = $urandom_range(0, 9) != 0;
      fl = $urandom_range(0, 11) == 0 ? int'($urandom_range(0, 1)) : -1;
      if (fl == 0) model_clear();
      model_op(we, a, wd, en, exp_rd, hit);
      if (fl == 1 && hit && !we) fl = -1;
      if (fl == 1) model_clear();
      cache_en = en;
      do_op(we, a, wd, fl, rd, lat, n);
      e = last_ext();
      checks++;
      if (n !== ((!we && hit) ? 0 : 1)) begin
        errors++;
        $display("FAIL rand_ext_count[%0d] got=%0d want=%0d", k, n, (!we && hit) ? 0 : 1);
      end
      if (n == 1) begin
        checks++;
        if (e.we !== we || e.addr !== a || (we && e.wdata !== wd)) begin
          errors++;
          $display("FAIL rand_ext_req[%0d] got we=%b addr=%h wdata=%h want %b %h %h", k, e.we, e.addr, e.wdata, we, a, wd);
        end
      end
      if (!we) begin
        checks++;
        if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d] addr=%h got=%h want=%h", k, a, rd, exp_rd); end
      end
      checks++;
      if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses)) begin
        errors++;
        $display("FAIL rand_counts[%0d] got hit=%0d miss=%0d want %0d %0d", k, hit_count, miss_count, m_hits, m_misses);
      end
      if (fl < 0 && prev_fl != 1) begin
        exp_lat = (!we && hit) ? 1 : resp_lat + 1;
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", k, lat, exp_lat); end
      end
      prev_fl = fl;
    end
  endtask
  initial begin
    reset = 1'b1;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    cache_en = 1'b1;
    flush = 1'b0;
    test_reset();
    test_basic();
    test_conflict();
    test_write();
    test_flush();
    test_bypass();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
